// File: rtl/ps2_key_decoder_pkg.sv
// Shared definitions for the PS/2 key decoder: scan-code constants, FSM
// state encoding and the key-event FIFO entry layout.
package ps2_key_decoder_pkg;

    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_BAT  = 8'hAA;
    localparam logic [7:0] SC_ACK  = 8'hFA;
    localparam logic [7:0] SC_RSND = 8'hFE;
    localparam logic [7:0] SC_ECHO = 8'hEE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } key_entry_t;

    localparam int unsigned ENTRY_W = $bits(key_entry_t);

    // Keyboard housekeeping replies that never represent a key event.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RSND) || (b == SC_ECHO);
    endfunction

endpackage

// File: rtl/ps2_key_decoder_key_fifo.sv
// Key-event FIFO: storage plus wrap-bit pointers; accepts a push into a full
// FIFO only when a pop frees a slot in the same cycle.
module key_fifo
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       push,
    input  key_entry_t wr_data,
    input  logic       pop,
    output key_entry_t rd_data,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    key_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd_en = pop && !empty;
        wr_en = push && (!full || rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        rd_data = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into key events, queues them
// in key_fifo and exposes code/status bytes on a processor read port.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  RD_PORT    = 8'h70,
    parameter logic [7:0]  STAT_PORT  = 8'h71
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic [7:0] ID_Port,
    input  logic       Read_Strobe,
    output logic [7:0] Data_Out,
    output logic       Key_Valid,
    output logic       Overflow
);

    dec_state_e state_q, state_d;
    logic       overflow_q, overflow_d;
    logic       push;
    key_entry_t push_entry;
    logic       pop_req;
    logic       stat_rd;
    logic       drop;
    key_entry_t head;
    logic       full;
    logic       empty;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        push       = 1'b0;
        push_entry = '0;
        if (rx_done_tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_data == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (rx_data == SC_BRK) begin
                        state_d = ST_BRK;
                    end else if (!is_discard(rx_data)) begin
                        push       = 1'b1;
                        push_entry = '{brk: 1'b0, ext: 1'b0, code: rx_data};
                    end
                end
                ST_EXT: begin
                    if (rx_data == SC_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (rx_data != SC_EXT) begin
                        push       = 1'b1;
                        push_entry = '{brk: 1'b0, ext: 1'b1, code: rx_data};
                        state_d    = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (rx_data != SC_BRK) begin
                        push       = 1'b1;
                        push_entry = '{brk: 1'b1, ext: 1'b0, code: rx_data};
                        state_d    = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if (rx_data != SC_BRK) begin
                        push       = 1'b1;
                        push_entry = '{brk: 1'b1, ext: 1'b1, code: rx_data};
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A pending drop wins over a status-read clear in the same cycle.
    always_comb begin
        pop_req    = Read_Strobe && (ID_Port == RD_PORT);
        stat_rd    = Read_Strobe && (ID_Port == STAT_PORT);
        drop       = push && full && !pop_req;
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (stat_rd) begin
            overflow_d = 1'b0;
        end
    end

    key_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_key_fifo (
        .CLK    (CLK),
        .Reset  (Reset),
        .push   (push),
        .wr_data(push_entry),
        .pop    (pop_req),
        .rd_data(head),
        .full   (full),
        .empty  (empty)
    );

    always_comb begin
        Key_Valid = !empty;
        Overflow  = overflow_q;
        Data_Out  = '0;
        if (ID_Port == RD_PORT) begin
            Data_Out = empty ? 8'h00 : head.code;
        end else if (ID_Port == STAT_PORT) begin
            Data_Out = {!empty, full, overflow_q, 3'b000,
                        head.brk & !empty, head.ext & !empty};
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder with hand-computed
// expected read-port and status values.
module tb_ps2_key_decoder;

    localparam logic [7:0] RD   = 8'h70;
    localparam logic [7:0] STAT = 8'h71;
    localparam logic [7:0] NONE = 8'h00;

    logic       clk;
    logic       rst;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic [7:0] id_port;
    logic       read_strobe;
    logic [7:0] data_out;
    logic       key_valid;
    logic       overflow;

    int unsigned n_vec;
    int unsigned n_miss;

    ps2_key_decoder #(
        .FIFO_DEPTH(4),
        .RD_PORT   (8'h70),
        .STAT_PORT (8'h71)
    ) dut (
        .CLK         (clk),
        .Reset       (rst),
        .rx_done_tick(rx_done_tick),
        .rx_data     (rx_data),
        .ID_Port     (id_port),
        .Read_Strobe (read_strobe),
        .Data_Out    (data_out),
        .Key_Valid   (key_valid),
        .Overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic tick, input logic [7:0] b,
                         input logic [7:0] port, input logic strb);
        @(negedge clk);
        rx_done_tick = tick;
        rx_data      = b;
        id_port      = port;
        read_strobe  = strb;
        #1;
    endtask

    task automatic end_cycle;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        read_strobe  = 1'b0;
        rst          = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        apply(1'b1, b, NONE, 1'b0);
        end_cycle();
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        apply(1'b0, 8'h00, RD, 1'b1);
        chk(tag, data_out, exp);
        end_cycle();
    endtask

    task automatic stat_chk(input string tag, input logic [7:0] exp, input logic strb);
        apply(1'b0, 8'h00, STAT, strb);
        chk(tag, data_out, exp);
        end_cycle();
    endtask

    task automatic do_reset;
        apply(1'b0, 8'h00, NONE, 1'b0);
        rst = 1'b1;
        end_cycle();
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        rst = 1'b1;
        rx_done_tick = 1'b0;
        rx_data = 8'h00;
        id_port = NONE;
        read_strobe = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_valid", {7'b0, key_valid}, 8'h00);
        chk("rst_ovf", {7'b0, overflow}, 8'h00);
        stat_chk("rst_stat", 8'h00, 1'b0);
        pop_chk("rst_rd_empty", 8'h00);

        // Make then break of 1C
        send(8'h1C);
        chk("lat_valid", {7'b0, key_valid}, 8'h01);
        send(8'hF0);
        send(8'h1C);
        pop_chk("mk_code", 8'h1C);
        stat_chk("brk_stat", 8'h82, 1'b0);
        pop_chk("brk_code", 8'h1C);
        chk("drain_valid", {7'b0, key_valid}, 8'h00);

        // Extended make and break
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        stat_chk("ext_stat", 8'h81, 1'b0);
        apply(1'b0, 8'h00, 8'h55, 1'b0);
        chk("other_port", data_out, 8'h00);
        end_cycle();
        pop_chk("ext_code", 8'h75);
        stat_chk("extbrk_stat", 8'h83, 1'b0);
        pop_chk("extbrk_code", 8'h75);

        // Overflow: fifth event dropped
        send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
        chk("ovf_flag", {7'b0, overflow}, 8'h01);
        stat_chk("ovf_stat", 8'hE0, 1'b0);
        pop_chk("ovf_pop0", 8'h16);
        pop_chk("ovf_pop1", 8'h1E);
        pop_chk("ovf_pop2", 8'h26);
        pop_chk("ovf_pop3", 8'h25);
        stat_chk("ovf_stat_clr", 8'h20, 1'b1);
        chk("ovf_cleared", {7'b0, overflow}, 8'h00);
        pop_chk("empty_pop", 8'h00);
        chk("empty_pop_valid", {7'b0, key_valid}, 8'h00);

        // Full with simultaneous push and pop
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        apply(1'b1, 8'h45, RD, 1'b1);
        chk("pp_head", data_out, 8'h11);
        end_cycle();
        chk("pp_no_ovf", {7'b0, overflow}, 8'h00);
        stat_chk("pp_stat", 8'hC0, 1'b0);
        pop_chk("pp_pop0", 8'h22);
        pop_chk("pp_pop1", 8'h33);
        pop_chk("pp_pop2", 8'h44);
        pop_chk("pp_pop3", 8'h45);
        chk("pp_empty", {7'b0, key_valid}, 8'h00);

        // Drop in the same cycle as a status-read clear keeps Overflow set
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
        apply(1'b1, 8'h06, STAT, 1'b1);
        end_cycle();
        chk("ovf_hold", {7'b0, overflow}, 8'h01);
        stat_chk("ovf_hold_stat", 8'hE0, 1'b0);
        do_reset();
        chk("rst2_valid", {7'b0, key_valid}, 8'h00);
        chk("rst2_ovf", {7'b0, overflow}, 8'h00);

        // Reset discards a pending E0 prefix
        send(8'hE0);
        do_reset();
        send(8'h1C);
        stat_chk("pfx_stat", 8'h80, 1'b0);
        pop_chk("pfx_code", 8'h1C);

        // Reset overrides a same-cycle byte
        apply(1'b1, 8'h29, NONE, 1'b0);
        rst = 1'b1;
        end_cycle();
        chk("rst_ovr_valid", {7'b0, key_valid}, 8'h00);

        // Housekeeping bytes are discarded
        send(8'hAA);
        send(8'hFA);
        chk("discard_valid", {7'b0, key_valid}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
